// File: rtl/sysu_tdm_pkg.sv
// Shared types and sizing helpers for the 4-slot TDM receiver that sits behind a
// 74LS153 dual 4-to-1 mux.
package sysu_tdm_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } tdm_state_t;

   localparam int SLOTS  = 4;
   localparam int SLOT_W = 2;

   // Hold counter width: ceil(log2(HOLD)) bits, never narrower than one bit.
   function automatic int cnt_width(input int hold);
      return (hold <= 1) ? 1 : $clog2(hold);
   endfunction

endpackage

// File: rtl/sysu_tdm_demux4_if.sv
// Mux-side signal bundle: select/enable drive, mux outputs back in, and the
// reconstructed parallel words out.
interface sysu_tdm_demux4_if;

   logic       en;
   logic       sel_a;
   logic       sel_b;
   logic       e1_n;
   logic       e2_n;
   logic       y1;
   logic       y2;
   logic [3:0] q1;
   logic [3:0] q2;
   logic       valid;
   logic       busy;

   modport master (
      input  en, y1, y2,
      output sel_a, sel_b, e1_n, e2_n, q1, q2, valid, busy
   );

   modport slave (
      output en, y1, y2,
      input  sel_a, sel_b, e1_n, e2_n, q1, q2, valid, busy
   );

endinterface

// File: rtl/sysu_tdm_slot_cnt.sv
// Hold/slot counter: counts HOLD cycles per slot, strobes on the last one and
// advances the 2-bit slot index modulo 4.
module sysu_tdm_slot_cnt
   import sysu_tdm_pkg::*;
#(
   parameter int HOLD = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   output logic [SLOT_W-1:0] o_slot,
   output logic              o_stb
);

   localparam int                CNT_W    = cnt_width(HOLD);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD - 1);

   logic [CNT_W-1:0]  r_cnt;
   logic [SLOT_W-1:0] r_slot;
   logic              w_at_last;

   assign w_at_last = (r_cnt == CNT_LAST);
   assign o_stb     = i_en && w_at_last;
   assign o_slot    = r_slot;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt  <= '0;
         r_slot <= '0;
      end else if (i_en) begin
         if (w_at_last) begin
            r_cnt  <= '0;
            r_slot <= r_slot + SLOT_W'(1);
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sysu_tdm_demux4.sv
// Scans the four mux slots, samples Y1/Y2 per slot and delivers the rebuilt
// D1/D2 words with a one-cycle valid pulse once all four slots are captured.
module sysu_tdm_demux4
   import sysu_tdm_pkg::*;
#(
   parameter int HOLD = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   sysu_tdm_demux4_if.master         bus
);

   localparam logic [0:0]        S_IDLE    = 1'(ST_IDLE);
   localparam logic [0:0]        S_SCAN    = 1'(ST_SCAN);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

   logic [0:0]        r_state;
   logic [2:0]        r_sh1;
   logic [2:0]        r_sh2;
   logic [3:0]        r_q1;
   logic [3:0]        r_q2;
   logic              r_valid;

   logic              w_run;
   logic              w_stb;
   logic              w_last;
   logic              w_clr;
   logic [SLOT_W-1:0] w_slot;

   assign w_run  = (r_state == S_SCAN);
   assign w_last = w_stb && (w_slot == SLOT_LAST);
   // Counter is held at slot 0 whenever the next cycle will not be scanning.
   assign w_clr  = !w_run || (!bus.en && !w_last) || (w_last && !bus.en);

   sysu_tdm_slot_cnt #(
      .HOLD (HOLD)
   ) u_slot_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_en   (w_run),
      .o_slot (w_slot),
      .o_stb  (w_stb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else if (!w_run) begin
         r_state <= bus.en ? S_SCAN : S_IDLE;
      end else if (w_last) begin
         r_state <= bus.en ? S_SCAN : S_IDLE;
      end else if (!bus.en) begin
         r_state <= S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !w_run) begin
         r_sh1 <= '0;
         r_sh2 <= '0;
      end else if (w_stb) begin
         case (w_slot)
            2'd0:    begin r_sh1[0] <= bus.y1; r_sh2[0] <= bus.y2; end
            2'd1:    begin r_sh1[1] <= bus.y1; r_sh2[1] <= bus.y2; end
            2'd2:    begin r_sh1[2] <= bus.y1; r_sh2[2] <= bus.y2; end
            default: ;
         endcase
      end
   end

   // Slot 3 comes straight from the mux so the word is complete on this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q1    <= '0;
         r_q2    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_run && w_last;
         if (w_run && w_last) begin
            r_q1 <= {bus.y1, r_sh1};
            r_q2 <= {bus.y2, r_sh2};
         end
      end
   end

   assign bus.sel_a = w_slot[0];
   assign bus.sel_b = w_slot[1];
   assign bus.e1_n  = !w_run;
   assign bus.e2_n  = !w_run;
   assign bus.busy  = w_run;
   assign bus.q1    = r_q1;
   assign bus.q2    = r_q2;
   assign bus.valid = r_valid;

endmodule

// File: tb/tb_sysu_tdm_demux4.sv
// Directed bench: two receivers (HOLD=1 and HOLD=3), each behind a behavioural
// 74LS153 model fed from bench-held D words.
module tb_sysu_tdm_demux4;

   logic       clk;
   logic       rst1;
   logic       rst3;
   logic [3:0] d1_a, d2_a;
   logic [3:0] d1_b, d2_b;
   int         n_chk;
   int         n_err;

   sysu_tdm_demux4_if bus1 ();
   sysu_tdm_demux4_if bus3 ();

   sysu_tdm_demux4 #(.HOLD(1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));
   sysu_tdm_demux4 #(.HOLD(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

   // 74LS153: output forced low while its group enable is high.
   assign bus1.y1 = bus1.e1_n ? 1'b0 : d1_a[{bus1.sel_b, bus1.sel_a}];
   assign bus1.y2 = bus1.e2_n ? 1'b0 : d2_a[{bus1.sel_b, bus1.sel_a}];
   assign bus3.y1 = bus3.e1_n ? 1'b0 : d1_b[{bus3.sel_b, bus3.sel_a}];
   assign bus3.y2 = bus3.e2_n ? 1'b0 : d2_b[{bus3.sel_b, bus3.sel_a}];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst1 = 1'b1; rst3 = 1'b1;
      bus1.en = 1'b0; bus3.en = 1'b0;
      d1_a = 4'hA; d2_a = 4'h6;
      d1_b = 4'h5; d2_b = 4'hC;
      step(); step();
      rst1 = 1'b0; rst3 = 1'b0;

      chk("rst_q1",    32'(bus1.q1), 32'h0);
      chk("rst_q2",    32'(bus1.q2), 32'h0);
      chk("rst_valid", 32'(bus1.valid), 32'h0);
      chk("rst_busy",  32'(bus1.busy), 32'h0);
      chk("rst_en_n",  32'({bus1.e1_n, bus1.e2_n}), 32'h3);
      chk("rst_sel",   32'({bus1.sel_b, bus1.sel_a}), 32'h0);

      // HOLD=1 continuous run: edge 0 enters SCAN, valid after every 4th edge.
      bus1.en = 1'b1;
      step();
      chk("h1_busy0", 32'(bus1.busy), 32'h1);
      chk("h1_en_n0", 32'({bus1.e1_n, bus1.e2_n}), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk($sformatf("h1_valid_e%0d", i), 32'(bus1.valid), 32'((i % 4) == 0));
         chk($sformatf("h1_sel_e%0d", i), 32'({bus1.sel_b, bus1.sel_a}), 32'(i % 4));
         if (i == 4) begin
            chk("h1_q1", 32'(bus1.q1), 32'hA);
            chk("h1_q2", 32'(bus1.q2), 32'h6);
         end
      end

      // Word change on a frame boundary: no mixed-frame word.
      d1_a = 4'h0;
      repeat (4) step();
      chk("chg_valid0", 32'(bus1.valid), 32'h1);
      chk("chg_q1_0",   32'(bus1.q1), 32'h0);
      d1_a = 4'hF;
      repeat (4) step();
      chk("chg_validF", 32'(bus1.valid), 32'h1);
      chk("chg_q1_F",   32'(bus1.q1), 32'hF);
      chk("chg_q2_6",   32'(bus1.q2), 32'h6);

      // Abort during slot 2 after a frame holding q1=3.
      d1_a = 4'h3;
      repeat (4) step();
      chk("ab_pre_q1", 32'(bus1.q1), 32'h3);
      step(); step();
      chk("ab_slot2", 32'({bus1.sel_b, bus1.sel_a}), 32'h2);
      bus1.en = 1'b0;
      d1_a = 4'hF;
      step();
      chk("ab_busy",  32'(bus1.busy), 32'h0);
      chk("ab_en_n",  32'({bus1.e1_n, bus1.e2_n}), 32'h3);
      chk("ab_valid", 32'(bus1.valid), 32'h0);
      chk("ab_sel",   32'({bus1.sel_b, bus1.sel_a}), 32'h0);
      step();
      chk("ab_valid2", 32'(bus1.valid), 32'h0);
      chk("ab_q1",     32'(bus1.q1), 32'h3);

      // en dropped exactly on the slot-3 sample edge: frame still delivered.
      d1_a = 4'h9;
      bus1.en = 1'b1;
      repeat (4) step();
      bus1.en = 1'b0;
      step();
      chk("l3_valid", 32'(bus1.valid), 32'h1);
      chk("l3_q1",    32'(bus1.q1), 32'h9);
      chk("l3_busy",  32'(bus1.busy), 32'h0);
      step();
      chk("l3_valid2", 32'(bus1.valid), 32'h0);
      chk("l3_en_n",   32'({bus1.e1_n, bus1.e2_n}), 32'h3);

      // Reset on the slot-3 sample edge wins over the capture.
      d1_a = 4'hC;
      bus1.en = 1'b1;
      repeat (4) step();
      rst1 = 1'b1;
      step();
      chk("rs_q1",    32'(bus1.q1), 32'h0);
      chk("rs_q2",    32'(bus1.q2), 32'h0);
      chk("rs_valid", 32'(bus1.valid), 32'h0);
      chk("rs_sel",   32'({bus1.sel_b, bus1.sel_a}), 32'h0);
      chk("rs_en_n",  32'({bus1.e1_n, bus1.e2_n}), 32'h3);
      chk("rs_busy",  32'(bus1.busy), 32'h0);
      rst1 = 1'b0;
      bus1.en = 1'b0;

      // HOLD=3: select advances every 3 edges, first valid after edge 12.
      bus3.en = 1'b1;
      step();
      for (int i = 1; i <= 13; i++) begin
         step();
         chk($sformatf("h3_valid_e%0d", i), 32'(bus3.valid), 32'(i == 12));
         chk($sformatf("h3_sel_e%0d", i), 32'({bus3.sel_b, bus3.sel_a}), 32'((i / 3) % 4));
         if (i == 12) begin
            chk("h3_q1", 32'(bus3.q1), 32'h5);
            chk("h3_q2", 32'(bus3.q2), 32'hC);
         end
      end
      bus3.en = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
